ctrl_ringaddr: RTL and testbench
================================

CTRL_RINGADDR -- requirements
Module: ctrl_ringaddr

Interface
REQ-001 Parameter WIDTH, default 3, register-file address width.
REQ-002 Parameter DEPTH, default 8, ring length per channel; legal range 2..2^WIDTH.
REQ-003 Parameter NCH, default 2, channel count; CHW = max(1, clog2(NCH)).
REQ-004 Port clk  input  1  clock; all registers SHALL update on the falling edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port en_init  input  1  start ring initialisation.
REQ-007 Port en_load  input  1  address load request.
REQ-008 Port new_smp  input  1  new input sample; advances the write pointer of ch_sel.
REQ-009 Port out_smp  input  1  output-sample phase; selects the newest ring entry.
REQ-010 Port ch_sel  input  CHW  channel select.
REQ-011 Port result_reg  input  WIDTH  tap offset behind the write pointer.
REQ-012 Port error_reg  input  WIDTH  error register address.
REQ-013 Port ares  output  WIDTH  result register-file address.
REQ-014 Port aerr  output  WIDTH  error register-file address.
REQ-015 Port addr_vld  output  1  ares/aerr valid strobe.
REQ-016 Port clr_we  output  1  clear-write strobe during initialisation.
REQ-017 Port busy  output  1  initialisation in progress.
REQ-018 Port ch_err  output  1  one-cycle pulse on an illegal ch_sel.

Function
REQ-019 FSM states SHALL be IDLE, INIT and RUN.
REQ-020 Transitions SHALL be: IDLE->INIT on en_init; INIT->RUN after DEPTH cycles; RUN->INIT on en_init (restart).
REQ-021 INIT SHALL step a sweep counter 0..DEPTH-1, one value per edge, as follows:
- clr_we=1, busy=1, addr_vld=0.
- ares=aerr=counter.
- all channel write pointers cleared to 0.
REQ-022 en_init asserted during INIT SHALL restart the sweep from 0.
REQ-023 In IDLE and INIT, en_load and new_smp SHALL be ignored; addr_vld=0.
REQ-024 In RUN, new_smp SHALL advance wptr[ch_sel] by 1, wrapping DEPTH-1 -> 0; other channels are unchanged.
REQ-025 In RUN, en_load with out_smp=0 SHALL register ares = (wptr[ch_sel] - off) mod DEPTH, where off = min(result_reg, DEPTH-1).
REQ-026 In RUN, en_load with out_smp=1 SHALL register ares = wptr[ch_sel].
REQ-027 In RUN, en_load SHALL register aerr = error_reg.
REQ-028 Latency SHALL be one falling edge: addr_vld=1 for exactly the cycle after each en_load.
REQ-029 When addr_vld=0 outside INIT, ares and aerr SHALL hold their last values; outputs are never high-impedance.
REQ-030 en_load and new_smp on the same channel in the same cycle: the address SHALL use the pre-increment pointer.
REQ-031 en_init and en_load in the same cycle: en_init SHALL win, and the load is dropped.
REQ-032 ch_sel >= NCH in RUN with en_load or new_smp SHALL leave pointers unchanged, keep addr_vld=0 and pulse ch_err for one cycle.
REQ-033 Modulo arithmetic SHALL use WIDTH+1 bits internally, so there is no overflow for DEPTH = 2^WIDTH.

Reset
REQ-034 rst_n=0 at a falling edge SHALL force all of the following, with reset taking priority over all inputs:
- state IDLE, all wptr = 0;
- ares = aerr = 0;
- addr_vld = clr_we = busy = ch_err = 0.
REQ-035 Reset asserted mid-INIT or mid-RUN SHALL abort the operation; no further clr_we pulses are produced.
REQ-036 After reset, the block SHALL require en_init before any address is issued.

Verification (WIDTH=3, DEPTH=6, NCH=2)
REQ-037 Reset, then pulse en_init -> busy=clr_we=1 for 6 cycles, ares=0,1,2,3,4,5, then RUN with busy=0.
REQ-038 In RUN, 7 new_smp pulses on ch0 -> wptr0=1 (wrap) and wptr1=0; verify with en_load, out_smp=1 on each channel: ares=1 and 0.
REQ-039 wptr0=1, en_load, result_reg=3, error_reg=5, out_smp=0 -> next cycle ares=4, aerr=5, addr_vld=1 for one cycle; result_reg=7 -> ares=2 (clamped to 5).
REQ-040 ch1 wptr=2, en_load+new_smp same cycle, result_reg=0 -> ares=2, and a later out_smp=1 load gives ares=3.
REQ-041 ch_sel=2 with en_load -> ch_err pulse, addr_vld=0, pointers unchanged.
REQ-042 rst_n low on the third INIT cycle -> next edge IDLE with all outputs 0; en_load is then ignored until a new en_init completes.

Source files
------------

// File: rtl/ctrl_ringaddr_if.sv
// Control/address bundle between a sequencer and ctrl_ringaddr.
// The master drives requests; the slave (ctrl_ringaddr) returns addresses and status.
interface ctrl_ringaddr_if #(
  parameter int WIDTH = 3,
  parameter int NCH   = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             en_init;
  logic             en_load;
  logic             new_smp;
  logic             out_smp;
  logic [CHW-1:0]   ch_sel;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] error_reg;
  logic [WIDTH-1:0] ares;
  logic [WIDTH-1:0] aerr;
  logic             addr_vld;
  logic             clr_we;
  logic             busy;
  logic             ch_err;

  modport master (
    output en_init, en_load, new_smp, out_smp, ch_sel, result_reg, error_reg,
    input  ares, aerr, addr_vld, clr_we, busy, ch_err
  );

  modport slave (
    input  en_init, en_load, new_smp, out_smp, ch_sel, result_reg, error_reg,
    output ares, aerr, addr_vld, clr_we, busy, ch_err
  );
endinterface

// File: rtl/ctrl_ringaddr.sv
// Per-channel ring-buffer address generator with a clear-sweep initialisation.
// All state updates on the falling edge of clk; rst_n is synchronous.
//
// state | meaning
// IDLE  | after reset, waits for en_init, no addresses issued
// INIT  | sweeps 0..DEPTH-1 with clr_we, clears every write pointer
// RUN   | tracks write pointers and issues tap/newest addresses on en_load
module ctrl_ringaddr #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int NCH   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_ringaddr_if.slave bus
);
  localparam logic [WIDTH:0] L_DEPTH = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0] L_LAST  = (WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH:0]   r_cnt, w_cnt_nx;
  logic [WIDTH:0]   r_wptr    [NCH];
  logic [WIDTH:0]   w_wptr_nx [NCH];
  logic [WIDTH-1:0] r_ares, w_ares_nx;
  logic [WIDTH-1:0] r_aerr, w_aerr_nx;
  logic             r_addr_vld, w_addr_vld_nx;
  logic             r_ch_err, w_ch_err_nx;

  logic             w_ch_ok;
  logic [WIDTH:0]   w_wsel;
  logic [WIDTH:0]   w_off;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_tap;
  logic [WIDTH:0]   w_inc;

  // Pointer arithmetic is done one bit wider so DEPTH = 2^WIDTH cannot overflow.
  always_comb begin
    w_ch_ok = (int'(bus.ch_sel) < NCH);
    w_wsel  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(bus.ch_sel) == i) w_wsel = r_wptr[i];
    end
    w_off = (int'(bus.result_reg) > DEPTH - 1) ? L_LAST : {1'b0, bus.result_reg};
    w_sum = w_wsel + L_DEPTH - w_off;
    w_tap = (w_sum >= L_DEPTH) ? WIDTH'(w_sum - L_DEPTH) : w_sum[WIDTH-1:0];
    w_inc = (w_wsel == L_LAST) ? '0 : w_wsel + 1'b1;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_ares_nx     = r_ares;
    w_aerr_nx     = r_aerr;
    w_addr_vld_nx = 1'b0;
    w_ch_err_nx   = 1'b0;
    for (int i = 0; i < NCH; i++) w_wptr_nx[i] = r_wptr[i];

    if (bus.en_init) begin
      // Entering or restarting the sweep; a coincident load is dropped.
      w_state_nx = INIT;
      w_cnt_nx   = '0;
      w_ares_nx  = '0;
      w_aerr_nx  = '0;
      for (int i = 0; i < NCH; i++) w_wptr_nx[i] = '0;
    end else begin
      case (r_state)
        IDLE: ;
        INIT: begin
          for (int i = 0; i < NCH; i++) w_wptr_nx[i] = '0;
          if (r_cnt == L_LAST) begin
            w_state_nx = RUN;
          end else begin
            w_cnt_nx  = r_cnt + 1'b1;
            w_ares_nx = w_cnt_nx[WIDTH-1:0];
            w_aerr_nx = w_cnt_nx[WIDTH-1:0];
          end
        end
        RUN: begin
          if (bus.en_load || bus.new_smp) begin
            if (!w_ch_ok) begin
              w_ch_err_nx = 1'b1;
            end else begin
              if (bus.new_smp) begin
                for (int i = 0; i < NCH; i++) begin
                  if (int'(bus.ch_sel) == i) w_wptr_nx[i] = w_inc;
                end
              end
              if (bus.en_load) begin
                w_addr_vld_nx = 1'b1;
                w_ares_nx     = bus.out_smp ? w_wsel[WIDTH-1:0] : w_tap;
                w_aerr_nx     = bus.error_reg;
              end
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ares     <= '0;
      r_aerr     <= '0;
      r_addr_vld <= 1'b0;
      r_ch_err   <= 1'b0;
      for (int i = 0; i < NCH; i++) r_wptr[i] <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_ares     <= w_ares_nx;
      r_aerr     <= w_aerr_nx;
      r_addr_vld <= w_addr_vld_nx;
      r_ch_err   <= w_ch_err_nx;
      for (int i = 0; i < NCH; i++) r_wptr[i] <= w_wptr_nx[i];
    end
  end

  assign bus.ares     = r_ares;
  assign bus.aerr     = r_aerr;
  assign bus.addr_vld = r_addr_vld;
  assign bus.ch_err   = r_ch_err;
  assign bus.busy     = (r_state == INIT);
  assign bus.clr_we   = (r_state == INIT);
endmodule

// File: tb/tb_ctrl_ringaddr.sv
// Bench for ctrl_ringaddr: directed vector table, hand-written corner sequences,
// and random traffic against an arithmetic reference model.
module tb_ctrl_ringaddr;
  localparam int WIDTH = 3;
  localparam int DEPTH = 6;
  localparam int NCH   = 2;

  logic clk;
  logic rst_n;
  logic a_rst_n;

  ctrl_ringaddr_if #(.WIDTH(WIDTH), .NCH(NCH)) m_if ();
  ctrl_ringaddr_if #(.WIDTH(WIDTH), .NCH(3))   a_if ();

  ctrl_ringaddr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  // Three-channel instance: ch_sel is 2 bits wide, so an illegal channel exists.
  ctrl_ringaddr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(3)) u_aux (
    .clk   (clk),
    .rst_n (a_rst_n),
    .bus   (a_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit rst_n, init, load, smp, osmp;
    int ch, rr, er;
    int ares, aerr;
    bit vld, busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  int m_mode;   // 0 idle, 1 sweeping, 2 running
  int m_idx;
  int m_wp [NCH];
  int e_ares, e_aerr;
  bit e_vld, e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change half a cycle away from the falling edge; outputs are read
  // at the rising edge after the update.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drive(input bit r, input bit init, input bit load, input bit smp,
                       input bit osmp, input int ch, input int rr, input int er);
    rst_n           = r;
    m_if.en_init    = init;
    m_if.en_load    = load;
    m_if.new_smp    = smp;
    m_if.out_smp    = osmp;
    m_if.ch_sel     = 1'(ch);
    m_if.result_reg = 3'(rr);
    m_if.error_reg  = 3'(er);
  endtask

  task automatic adrive(input bit r, input bit init, input bit load, input bit smp,
                        input bit osmp, input int ch);
    a_rst_n         = r;
    a_if.en_init    = init;
    a_if.en_load    = load;
    a_if.new_smp    = smp;
    a_if.out_smp    = osmp;
    a_if.ch_sel     = 2'(ch);
    a_if.result_reg = '0;
    a_if.error_reg  = '0;
  endtask

  task automatic chk_main(input string tag, input int ares, input int aerr,
                          input bit vld, input bit busy, input bit err);
    chk({tag, ".ares"},     32'(m_if.ares),     32'(ares));
    chk({tag, ".aerr"},     32'(m_if.aerr),     32'(aerr));
    chk({tag, ".addr_vld"}, 32'(m_if.addr_vld), 32'(vld));
    chk({tag, ".busy"},     32'(m_if.busy),     32'(busy));
    chk({tag, ".clr_we"},   32'(m_if.clr_we),   32'(busy));
    chk({tag, ".ch_err"},   32'(m_if.ch_err),   32'(err));
  endtask

  task automatic chk_aux(input string tag, input int ares, input bit vld, input bit err);
    chk({tag, ".ares"},     32'(a_if.ares),     32'(ares));
    chk({tag, ".addr_vld"}, 32'(a_if.addr_vld), 32'(vld));
    chk({tag, ".ch_err"},   32'(a_if.ch_err),   32'(err));
  endtask

  task automatic model_step(input bit r, input bit init, input bit load, input bit smp,
                            input bit osmp, input int ch, input int rr, input int er);
    int off;
    e_vld = 1'b0;
    e_err = 1'b0;
    if (!r) begin
      m_mode = 0; m_idx = 0; e_ares = 0; e_aerr = 0;
      foreach (m_wp[i]) m_wp[i] = 0;
    end else if (init) begin
      m_mode = 1; m_idx = 0; e_ares = 0; e_aerr = 0;
      foreach (m_wp[i]) m_wp[i] = 0;
    end else if (m_mode == 1) begin
      if (m_idx == DEPTH - 1) m_mode = 2;
      else begin
        m_idx++;
        e_ares = m_idx;
        e_aerr = m_idx;
      end
    end else if (m_mode == 2 && (load || smp)) begin
      if (ch >= NCH) e_err = 1'b1;
      else begin
        if (load) begin
          off    = (rr < DEPTH - 1) ? rr : DEPTH - 1;
          e_vld  = 1'b1;
          e_ares = osmp ? m_wp[ch] : ((m_wp[ch] - off) % DEPTH + DEPTH) % DEPTH;
          e_aerr = er;
        end
        if (smp) m_wp[ch] = (m_wp[ch] + 1) % DEPTH;
      end
    end
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
    adrive(1'b0, 0, 0, 0, 0, 0);

    // rst, init, load, smp, osmp, ch, rr, er | ares, aerr, vld, busy
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1});
    for (int i = 1; i < DEPTH; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, i, i, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 5, 5, 1'b0, 1'b0});
    for (int i = 0; i < 7; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 5, 5, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1, 0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 2, 0, 2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 2, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 5, 4, 5, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4, 5, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 7, 5, 2, 5, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 2, 5, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 2, 5, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 2, 1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1, 3, 1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 3, 0, 3, 1'b1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].init, tbl[i].load, tbl[i].smp, tbl[i].osmp,
            tbl[i].ch, tbl[i].rr, tbl[i].er);
      tick();
      chk_main($sformatf("vec%0d", i), tbl[i].ares, tbl[i].aerr, tbl[i].vld, tbl[i].busy, 1'b0);
    end

    // en_init beats a coincident en_load, then reset lands on the third sweep cycle
    drive(1'b1, 1, 1, 0, 1, 0, 0, 7); tick(); chk_main("init_wins", 0, 0, 0, 1, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0); tick(); chk_main("sweep1", 1, 1, 0, 1, 0);
    tick();                                   chk_main("sweep2", 2, 2, 0, 1, 0);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0); tick(); chk_main("mid_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 1, 1, 1, i % 2, 0, 4); tick();
      chk_main($sformatf("post_rst_ign%0d", i), 0, 0, 0, 0, 0);
    end
    drive(1'b1, 1, 0, 0, 0, 0, 0, 0); tick(); chk_main("reinit", 0, 0, 0, 1, 0);
    drive(1'b1, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i < DEPTH; i++) begin
      tick(); chk_main($sformatf("reinit_sw%0d", i), i, i, 0, 1, 0);
    end
    tick(); chk_main("reinit_done", 5, 5, 0, 0, 0);
    drive(1'b1, 0, 1, 0, 1, 1, 0, 6); tick(); chk_main("reinit_load", 0, 6, 1, 0, 0);

    // Illegal channel on the three-channel instance
    tick();
    adrive(1'b1, 1, 0, 0, 0, 0); tick();
    adrive(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) tick();
    adrive(1'b1, 0, 1, 0, 1, 3); tick(); chk_aux("bad_load", 5, 0, 1);
    adrive(1'b1, 0, 0, 0, 0, 0); tick(); chk_aux("err_pulse_end", 5, 0, 0);
    adrive(1'b1, 0, 0, 1, 0, 3); tick(); chk_aux("bad_smp", 5, 0, 1);
    adrive(1'b1, 0, 0, 1, 0, 2); tick(); chk_aux("ch2_smp", 5, 0, 0);
    for (int c = 0; c < 3; c++) begin
      adrive(1'b1, 0, 1, 0, 1, c); tick();
      chk_aux($sformatf("aux_wptr%0d", c), (c == 2) ? 1 : 0, 1, 0);
    end

    // Random traffic against the reference model
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
    model_step(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 600; n++) begin
      bit r, ini, ld, sm, os;
      int ch, rr, er;
      r   = ($urandom_range(0, 79) != 0);
      ini = (n == 0) || ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 2) == 0);
      sm  = ($urandom_range(0, 2) == 0);
      os  = 1'($urandom_range(0, 1));
      ch  = $urandom_range(0, NCH - 1);
      rr  = $urandom_range(0, 7);
      er  = $urandom_range(0, 7);
      drive(r, ini, ld, sm, os, ch, rr, er);
      model_step(r, ini, ld, sm, os, ch, rr, er);
      tick();
      chk_main($sformatf("rnd%0d", n), e_ares, e_aerr, e_vld, (m_mode == 1), e_err);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
